// File: rtl/mux10.sv
// Registered 10:1 selector: Z takes I<S> one clock after S is sampled; codes 10-15 give zero and flag sel_err.
// Latency is one clock; there is no backpressure, and every edge loads a new value.
module mux10 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       S,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic [WIDTH-1:0] I8,
  input  logic [WIDTH-1:0] I9,
  output logic [WIDTH-1:0] Z,
  output logic             sel_err
);

  logic [WIDTH-1:0] sel_dat;
  logic             sel_bad;

  // Only the addressed input reaches sel_dat, so unknowns on other inputs stay out.
  always_comb begin
    sel_dat = '0;
    sel_bad = 1'b0;
    case (S)
      4'd0:    sel_dat = I0;
      4'd1:    sel_dat = I1;
      4'd2:    sel_dat = I2;
      4'd3:    sel_dat = I3;
      4'd4:    sel_dat = I4;
      4'd5:    sel_dat = I5;
      4'd6:    sel_dat = I6;
      4'd7:    sel_dat = I7;
      4'd8:    sel_dat = I8;
      4'd9:    sel_dat = I9;
      default: sel_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z       <= '0;
      sel_err <= 1'b0;
    end else begin
      Z       <= sel_dat;
      sel_err <= sel_bad;
    end
  end

endmodule

// File: tb/tb_mux10.sv
// Scoreboard bench for mux10: expectations queued at drive time, popped one edge later.
module tb_mux10;
  localparam int WIDTH = 8;

  typedef struct {
    string          tag;
    logic [WIDTH-1:0] z;
    logic           err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       S = 4'd0;
  logic [WIDTH-1:0] din [10];
  logic [WIDTH-1:0] Z;
  logic             sel_err;

  exp_t sb_q [$];
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux10 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .S(S),
    .I0(din[0]), .I1(din[1]), .I2(din[2]), .I3(din[3]), .I4(din[4]),
    .I5(din[5]), .I6(din[6]), .I7(din[7]), .I8(din[8]), .I9(din[9]),
    .Z(Z), .sel_err(sel_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a select code at the falling edge and queue what the next rising edge must produce.
  task automatic drive(input string tag, input int s);
    exp_t e;
    @(negedge clk);
    S = 4'(s);
    e.tag = tag;
    e.z   = (s < 10) ? din[s] : '0;
    e.err = (s >= 10);
    sb_q.push_back(e);
  endtask

  task automatic edge_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, "_z"}, 32'(Z), 32'(e.z));
      check({e.tag, "_err"}, 32'(sel_err), 32'(e.err));
    end
  endtask

  initial begin
    int vals [10] = '{1, 12, 51, 47, 22, 17, 83, 104, 7, 21};
    for (int i = 0; i < 10; i++) din[i] = WIDTH'(vals[i]);

    // Reset state across edges
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", 32'(Z), 32'd0);
    check("rst_err", 32'(sel_err), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int s = 0; s < 10; s++) begin
      drive($sformatf("sweep_s%0d", s), s);
      edge_check();
    end

    for (int s = 10; s < 16; s++) begin
      drive($sformatf("oor_s%0d", s), s);
      edge_check();
    end
    drive("recover_s3", 3);
    edge_check();

    // Hold S=7, change the selected and an unselected input mid-cycle
    drive("hold_s7", 7);
    edge_check();
    #2;
    din[7] = 8'd200;
    din[0] = 8'd99;
    #1;
    check("hold_mid_z", 32'(Z), 32'd104);
    drive("hold_s7_new", 7);
    edge_check();
    @(negedge clk);
    din[0] = 8'd5;
    drive("unsel_chg", 7);
    edge_check();

    // Asynchronous reset between edges discards the pending selection
    drive("pre_rst_s6", 6);
    edge_check();
    check("pre_rst_val", 32'(Z), 32'd83);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_z", 32'(Z), 32'd0);
    check("async_rst_err", 32'(sel_err), 32'd0);
    S = 4'd12;
    repeat (2) @(posedge clk);
    #1;
    check("in_rst_z", 32'(Z), 32'd0);
    check("in_rst_err", 32'(sel_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive("post_rst_s1", 1);
    edge_check();

    // Unknowns on unselected inputs
    for (int i = 0; i < 10; i++) if (i != 2) din[i] = 'x;
    drive("x_unsel_s2", 2);
    edge_check();
    check("x_free", 32'($isunknown(Z)), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
